board_refill: RTL and testbench

BOARD_REFILL -- requirements
Module: board_refill

---
 rtl/board_refill.sv | 127 ++++++++++++
 tb/tb_board_refill.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/board_refill.sv
// board_refill: gravity-drop an 8x8 colour board, then refill every empty
// cell with an LFSR-derived colour, scanning one cell per clock.
module board_refill #(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          NUM_COLORS = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [191:0] board_in,
  output logic [191:0] board_out,
  output logic         busy,
  output logic         done,
  output logic [6:0]   fill_count
);

  typedef enum logic [1:0] {IDLE, DROP, FILL, DONE} state_t;

  state_t       state_q, state_d;
  logic [191:0] board_q, board_d;
  logic [191:0] drop_board;
  logic [6:0]   fill_count_q, fill_count_d;
  logic [15:0]  lfsr_q, lfsr_d;
  logic [5:0]   idx_q, idx_d;
  logic         any_shift;
  logic [7:0]   cell_pos;
  logic [2:0]   cur_cell;
  logic [2:0]   new_color;
  logic         lfsr_fb;

  assign cell_pos  = {2'b00, idx_q} * 8'd3;
  assign cur_cell  = board_q[cell_pos +: 3];
  assign new_color = 3'((int'(lfsr_q[2:0]) % NUM_COLORS) + 1);
  assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // One gravity step: each column slides everything above its lowest hole.
  always_comb begin
    int   e;
    logic found;
    logic above;
    drop_board = board_q;
    any_shift  = 1'b0;
    for (int j = 0; j < 8; j++) begin
      e     = 0;
      found = 1'b0;
      above = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (board_q[(8*i+j)*3 +: 3] == 3'd0) begin
          e     = i;
          found = 1'b1;
        end
      end
      for (int i = 0; i < 8; i++) begin
        if (i < e && board_q[(8*i+j)*3 +: 3] != 3'd0)
          above = 1'b1;
      end
      if (found && above) begin
        any_shift = 1'b1;
        for (int i = 1; i < 8; i++) begin
          if (i <= e)
            drop_board[(8*i+j)*3 +: 3] = board_q[(8*(i-1)+j)*3 +: 3];
        end
        drop_board[j*3 +: 3] = 3'd0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    fill_count_d = fill_count_q;
    lfsr_d       = lfsr_q;
    idx_d        = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          board_d      = board_in;
          fill_count_d = 7'd0;
          idx_d        = 6'd0;
          state_d      = DROP;
        end
      end
      DROP: begin
        if (any_shift) begin
          board_d = drop_board;
        end else begin
          idx_d   = 6'd0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (cur_cell == 3'd0) begin
          board_d[cell_pos +: 3] = new_color;
          fill_count_d           = fill_count_q + 7'd1;
          lfsr_d                 = {lfsr_fb, lfsr_q[15:1]};
        end
        idx_d = idx_q + 6'd1;
        if (idx_q == 6'd63)
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      board_q      <= '0;
      fill_count_q <= 7'd0;
      lfsr_q       <= SEED;
      idx_q        <= 6'd0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      fill_count_q <= fill_count_d;
      lfsr_q       <= lfsr_d;
      idx_q        <= idx_d;
    end
  end

  assign board_out  = board_q;
  assign fill_count = fill_count_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_board_refill.sv
// tb_board_refill: random and directed boards against a gravity/fill
// reference model with its own LFSR copy.
module tb_board_refill;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          NC   = 5;

  logic         clk;
  logic         rst;
  logic         start;
  logic [191:0] board_in;
  logic [191:0] board_out;
  logic         busy;
  logic         done;
  logic [6:0]   fill_count;

  int n_tests;
  int n_fail;
  logic [15:0] m_lfsr;

  board_refill #(.SEED(SEED), .NUM_COLORS(NC)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .board_in   (board_in),
    .board_out  (board_out),
    .busy       (busy),
    .done       (done),
    .fill_count (fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] got,
                       input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  // Final board = per-column compaction to the bottom; d = the most holes
  // lying below the topmost occupied cell of any column.
  function automatic void model(input logic [191:0] b,
                                output logic [191:0] r,
                                output int d, output int fc);
    int top;
    int z;
    int k;
    r  = '0;
    d  = 0;
    fc = 0;
    for (int j = 0; j < 8; j++) begin
      top = -1;
      z   = 0;
      for (int i = 0; i < 8; i++)
        if (top < 0 && b[(8*i+j)*3 +: 3] != 0) top = i;
      if (top >= 0)
        for (int i = top + 1; i < 8; i++)
          if (b[(8*i+j)*3 +: 3] == 0) z++;
      if (z > d) d = z;
      k = 7;
      for (int i = 7; i >= 0; i--) begin
        if (b[(8*i+j)*3 +: 3] != 0) begin
          r[(8*k+j)*3 +: 3] = b[(8*i+j)*3 +: 3];
          k--;
        end
      end
    end
    for (int c = 0; c < 64; c++) begin
      if (r[c*3 +: 3] == 0) begin
        r[c*3 +: 3] = 3'((m_lfsr[2:0] % NC) + 1);
        fc++;
        m_lfsr = lfsr_step(m_lfsr);
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_board", board_out, '0);
    check("rst_fc", fill_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    m_lfsr = SEED;
  endtask

  task automatic run_op(input logic [191:0] b, input string tag,
                        input int pulse_at, output logic [191:0] res);
    logic [191:0] exp_b;
    int d, fc, edges, done_cnt, extra;
    logic busy_ok, nz_ok;
    model(b, exp_b, d, fc);
    @(negedge clk);
    board_in = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    edges    = 0;
    done_cnt = 0;
    busy_ok  = 1'b1;
    while (edges < 200) begin
      start = (edges == pulse_at);
      @(posedge clk);
      #1;
      edges++;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        done_cnt++;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, edges, d + 65);
    check({tag, "_busy"}, busy_ok, 1);
    check({tag, "_board"}, board_out, exp_b);
    check({tag, "_fc"}, fill_count, fc);
    nz_ok = 1'b1;
    for (int c = 0; c < 64; c++)
      if (board_out[c*3 +: 3] == 0) nz_ok = 1'b0;
    check({tag, "_full"}, nz_ok, 1);
    res   = board_out;
    extra = 0;
    @(posedge clk);
    #1;
    check({tag, "_idle"}, busy, 0);
    check({tag, "_hold"}, board_out, exp_b);
    if (done) extra++;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check({tag, "_one_done"}, done_cnt + extra, 1);
  endtask

  function automatic logic [191:0] rand_board();
    logic [191:0] b;
    for (int c = 0; c < 64; c++)
      b[c*3 +: 3] = ($urandom_range(0, 2) == 0) ? 3'd0
                    : 3'($urandom_range(1, 7));
    return b;
  endfunction

  initial begin
    logic [191:0] b, r1, r2;
    logic ok;
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    board_in = '0;
    m_lfsr   = SEED;

    do_reset();
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (board_out != 0 || busy || done) ok = 1'b0;
    end
    check("idle5", ok, 1);

    for (int c = 0; c < 64; c++) b[c*3 +: 3] = 3'd3;
    run_op(b, "all3", -1, r1);
    check("all3_same", r1, b);
    check("all3_fc0", fill_count, 0);

    for (int c = 0; c < 64; c++) b[c*3 +: 3] = 3'd4;
    for (int i = 0; i < 8; i++) b[(8*i)*3 +: 3] = (i < 5) ? 3'd2 : 3'd0;
    run_op(b, "col0", -1, r1);
    check("col0_fc3", fill_count, 3);
    ok = 1'b1;
    for (int i = 3; i < 8; i++) if (r1[(8*i)*3 +: 3] != 2) ok = 1'b0;
    for (int i = 0; i < 3; i++)
      if (r1[(8*i)*3 +: 3] < 1 || r1[(8*i)*3 +: 3] > NC) ok = 1'b0;
    check("col0_shape", ok, 1);

    do_reset();
    run_op('0, "zero_a", -1, r1);
    do_reset();
    run_op('0, "zero_b", -1, r2);
    check("zero_repeat", r2, r1);
    check("zero_fc64", fill_count, 64);
    ok = 1'b1;
    for (int c = 0; c < 64; c++)
      if (r2[c*3 +: 3] < 1 || r2[c*3 +: 3] > NC) ok = 1'b0;
    check("zero_range", ok, 1);

    b = rand_board();
    run_op(b, "restart", 20, r1);

    @(negedge clk);
    board_in = '0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    check("abort_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_board", board_out, '0);
    check("abort_fc", fill_count, 0);
    check("abort_busy0", busy, 0);
    ok = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) ok = 1'b0;
    end
    check("abort_nodone", ok, 1);
    @(negedge clk);
    rst    = 1'b0;
    m_lfsr = SEED;
    run_op(rand_board(), "after_abort", -1, r1);

    for (int t = 0; t < 20; t++)
      run_op(rand_board(), $sformatf("rand%0d", t), -1, r1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
